mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester and the data (load/store) requester.
- Sequences each RAM transaction from the RAM's ramstate_t status (FREE, BUSY, ACCESS, ERROR).
- Returns read data and completion or error to the granted requester.
- Sits between fetch/LSU and the RAM model; one outstanding transaction at a time.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles spent waiting for ACCESS/ERROR before an error completion is forced. Legal range 1..255.
- CNT_W, 8: width of the timeout counter.

Ports:
- clk  in  1  system clock
- nRst  in  1  asynchronous active-low reset
- i_req  in  1  instruction fetch request; held until i_ack
- i_addr  in  32  fetch address (word_t)
- i_ack  out  1  one-cycle fetch completion
- i_err  out  1  fetch error; valid only with i_ack
- i_data  out  33  imem_t {valid, data}; valid = i_ack & ~i_err
- d_ren  in  1  data read request; held until d_ack
- d_wen  in  1  data write request; held until d_ack
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_sel  in  4  byte enables
- d_ack  out  1  one-cycle data completion
- d_err  out  1  data error; valid only with d_ack
- d_rdata  out  32  load data; valid with d_ack
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_sel  out  4  RAM byte enables; 4'hF for fetch
- ram_rdata  in  32  RAM read data
- ram_state  in  2  ramstate_t status
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, nRst=0):
  - State = IDLE.
  - All outputs = 0, including i_data and d_rdata.
  - last_grant = INSTR, so data wins the first contention.
  - Counter = 0.
  - ram_ren and ram_wen drop immediately, including mid-transaction. No ack is issued for the aborted transaction.
- States:
  - IDLE: no request outstanding.
  - IWAIT: fetch transaction in progress.
  - DWAIT: data transaction in progress.
  - DONE: single cycle; the selected ack is high.
- IDLE arbitration, evaluated each cycle:
  - d_ren & d_wen together: go to DONE with d_ack=1, d_err=1. No RAM access.
  - Data only (d_ren^d_wen): go to DWAIT.
  - i_req only: go to IWAIT.
  - Both requesting: grant the requester not in last_grant (round-robin). last_grant updates on every grant.
- Grant timing (registered outputs):
  - A request sampled in IDLE at edge N drives ram_* valid from cycle N+1.
  - Address, data, sel and strobe are captured at grant. They stay stable until leaving WAIT, regardless of later requester input changes.
  - A fetch drives ram_ren=1 and ram_sel=4'hF.
- IWAIT/DWAIT, per cycle:
  - ram_state == ACCESS: capture ram_rdata, deassert strobes, go to DONE with err=0.
  - ram_state == ERROR: deassert strobes, go to DONE with err=1. Read data = 0.
  - ram_state == FREE or BUSY: stay and increment the counter.
  - Counter reaches TIMEOUT_CYC: go to DONE with err=1.
  - Counter clears on entry to WAIT.
- DONE:
  - Exactly one of i_ack/d_ack is high for one cycle, with err and data.
  - Unconditionally returns to IDLE.
  - Requesters deassert after seeing ack, so no double grant occurs.
- Minimum latency is 3 cycles from request to ack: grant edge, ACCESS in the first WAIT cycle, ack in DONE.
- A request dropped mid-transaction does not abort it; ack is still issued.
- Requests asserted while busy wait; nothing is queued beyond the held request lines.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100; RAM gives BUSY×2 then ACCESS with rdata=0xDEADBEEF.
  -> ram_ren=1, ram_addr=0x100, ram_sel=F for 3 cycles.
  -> i_ack one cycle with i_data={1,0xDEADBEEF}.
- Contention after reset: i_req and d_ren (addr 0x200) asserted together.
  -> Data is granted first; d_ack precedes the fetch.
  -> The fetch is granted in the next IDLE; the following contention grants data again (alternation).
- Store: d_wen=1, d_addr=0x40, d_wdata=0x12345678, d_sel=4'b0011; ACCESS.
  -> ram_wen=1 with exactly those values held.
  -> d_ack=1, d_err=0; ram_ren stays 0.
- Error paths:
  - ram_state=ERROR during DWAIT -> d_ack=1, d_err=1, d_rdata=0.
  - d_ren&d_wen -> d_ack/d_err without any ram strobe.
- Timeout: TIMEOUT_CYC=4, RAM held BUSY -> i_ack=1, i_err=1, i_data.valid=0 in the DONE cycle after 4 waiting cycles.
- Reset mid-DWAIT: assert nRst=0 asynchronously.
  -> ram_wen/ram_ren fall without a clock edge; busy=0; no d_ack.
  -> After release, a new fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Fetch/LSU arbiter onto the single RAM port.
// One transaction in flight; round-robin on contention.
package mem_arbiter_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef struct packed {
    logic  valid;
    word_t data;
  } imem_t;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [32:0] i_data,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_sel,
  input  logic [31:0] ram_rdata,
  input  logic [1:0]  ram_state,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IWAIT = 2'd1,
    DWAIT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    G_INSTR = 1'b0,
    G_DATA  = 1'b1
  } grant_e;

  state_e     state_q, state_d;
  grant_e     last_q;
  logic [CNT_W-1:0] cnt_q;
  ramstate_t  rs;
  logic       d_req, d_bad;
  logic       take_d, take_i;
  logic       acc, rerr, tmo;
  logic       wait_end;
  imem_t      i_data_q;

  assign rs    = ramstate_t'(ram_state);
  assign d_req = d_ren | d_wen;
  assign d_bad = d_ren & d_wen;

  // Data wins unless it was the last one served.
  assign take_d = d_req & (~i_req | (last_q == G_INSTR));
  assign take_i = i_req & ~take_d;

  assign acc      = (rs == ACCESS);
  assign rerr     = (rs == ERROR);
  assign tmo      = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign wait_end = acc | rerr | tmo;

  assign busy   = (state_q != IDLE);
  assign i_data = i_data_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          take_d:  state_d = d_bad ? DONE : DWAIT;
          take_i:  state_d = IWAIT;
          default: state_d = IDLE;
        endcase
      end
      IWAIT,
      DWAIT: if (wait_end) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      last_q    <= G_INSTR;
      cnt_q     <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_sel   <= '0;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      i_data_q  <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      i_ack    <= 1'b0;
      i_err    <= 1'b0;
      i_data_q <= '0;
      d_ack    <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            take_d: begin
              last_q <= G_DATA;
              cnt_q  <= '0;
              if (d_bad) begin
                d_ack <= 1'b1;
                d_err <= 1'b1;
              end else begin
                ram_ren   <= d_ren;
                ram_wen   <= d_wen;
                ram_addr  <= d_addr;
                ram_wdata <= d_wdata;
                ram_sel   <= d_sel;
              end
            end
            take_i: begin
              last_q    <= G_INSTR;
              cnt_q     <= '0;
              ram_ren   <= 1'b1;
              ram_wen   <= 1'b0;
              ram_addr  <= i_addr;
              ram_wdata <= '0;
              ram_sel   <= 4'hF;
            end
            default: ;
          endcase
        end
        IWAIT,
        DWAIT: begin
          if (wait_end) begin
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            if (state_q == IWAIT) begin
              i_ack    <= 1'b1;
              i_err    <= ~acc;
              i_data_q <= '{valid: acc,
                            data: acc ? ram_rdata : '0};
            end else begin
              d_ack   <= 1'b1;
              d_err   <= ~acc;
              d_rdata <= acc ? ram_rdata : '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
